// File: rtl/exec_sequencer_pkg.sv
// Shared definitions for the four-state instruction sequencer: state encoding,
// instruction field positions, ALU op codes and the counter width default.
package exec_sequencer_pkg;

    localparam int CNT_W_DEFAULT = 16;
    localparam int INSTR_W       = 16;

    localparam int NO_WB_BIT = 15;
    localparam int OP_MSB    = 14;
    localparam int OP_LSB    = 12;
    localparam int RD_MSB    = 11;
    localparam int RD_LSB    = 8;
    localparam int RS1_MSB   = 7;
    localparam int RS1_LSB   = 4;
    localparam int RS2_MSB   = 3;
    localparam int RS2_LSB   = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101,
        ALU_SLL = 3'b110,
        ALU_SRL = 3'b111
    } alu_op_e;

    typedef struct packed {
        logic       no_wb;
        alu_op_e    op;
        logic [3:0] rd;
        logic [3:0] rs1;
        logic [3:0] rs2;
    } instr_fields_t;

endpackage

// File: rtl/exec_sequencer_instr_decode.sv
// Purely combinational split of a 16-bit instruction word into its fields.
module instr_decode
    import exec_sequencer_pkg::*;
(
    input  logic [INSTR_W-1:0] i_instr,
    output instr_fields_t      o_fields
);

    always_comb begin
        o_fields = '{
            no_wb: i_instr[NO_WB_BIT],
            op:    alu_op_e'(i_instr[OP_MSB:OP_LSB]),
            rd:    i_instr[RD_MSB:RD_LSB],
            rs1:   i_instr[RS1_MSB:RS1_LSB],
            rs2:   i_instr[RS2_MSB:RS2_LSB]
        };
    end

endmodule

// File: rtl/exec_sequencer.sv
// Four-cycle instruction sequencer: accept, read operands, capture ALU result,
// then write back and retire. One instruction in flight, no queueing.
module exec_sequencer
    import exec_sequencer_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               instr_valid,
    input  logic [15:0]        instr_in,
    output logic               instr_ready,
    output logic [3:0]         read_reg1,
    output logic [3:0]         read_reg2,
    output logic [2:0]         alu_ctrl,
    input  logic [31:0]        alu_result,
    input  logic               alu_zero,
    output logic [3:0]         write_reg,
    output logic [31:0]        write_data,
    output logic               reg_write,
    output logic               done,
    output logic               zero_flag,
    output logic               busy,
    output logic [CNT_W-1:0]   instr_count
);

    state_e           r_state;
    logic [15:0]      r_instr;
    logic             r_ready;
    logic             r_busy;
    logic [3:0]       r_write_reg;
    logic [31:0]      r_write_data;
    logic             r_reg_write;
    logic             r_done;
    logic             r_zero_pending;
    logic             r_zero_flag;
    logic [CNT_W-1:0] r_instr_count;

    instr_fields_t    w_fields;

    // Read addresses and op are decoded from the held instruction, so they stay
    // stable from READ through WB and read as zero after reset.
    instr_decode u_decode (
        .i_instr  (r_instr),
        .o_fields (w_fields)
    );

    // NOTE: every register here updates with non-blocking assignments so all
    // state moves together on the edge regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_instr        <= '0;
            r_ready        <= 1'b1;
            r_busy         <= 1'b0;
            r_write_reg    <= '0;
            r_write_data   <= '0;
            r_reg_write    <= 1'b0;
            r_done         <= 1'b0;
            r_zero_pending <= 1'b0;
            r_zero_flag    <= 1'b0;
            r_instr_count  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (instr_valid) begin
                        r_instr <= instr_in;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= ST_READ;
                    end
                end
                ST_READ: begin
                    r_state <= ST_EXEC;
                end
                ST_EXEC: begin
                    r_write_data   <= alu_result;
                    r_zero_pending <= alu_zero;
                    r_write_reg    <= w_fields.rd;
                    r_reg_write    <= ~w_fields.no_wb;
                    r_done         <= 1'b1;
                    r_state        <= ST_WB;
                end
                ST_WB: begin
                    r_reg_write   <= 1'b0;
                    r_done        <= 1'b0;
                    r_zero_flag   <= r_zero_pending;
                    r_instr_count <= r_instr_count + CNT_W'(1);
                    r_ready       <= 1'b1;
                    r_busy        <= 1'b0;
                    r_state       <= ST_IDLE;
                end
                default: begin
                    r_reg_write <= 1'b0;
                    r_done      <= 1'b0;
                    r_ready     <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign instr_ready = r_ready;
    assign busy        = r_busy;
    assign read_reg1   = w_fields.rs1;
    assign read_reg2   = w_fields.rs2;
    assign alu_ctrl    = w_fields.op;
    assign write_reg   = r_write_reg;
    assign write_data  = r_write_data;
    assign reg_write   = r_reg_write;
    assign done        = r_done;
    assign zero_flag   = r_zero_flag;
    assign instr_count = r_instr_count;

endmodule

// File: tb/tb_exec_sequencer.sv
// Scoreboard bench for exec_sequencer with a behavioural register file and ALU.
module tb_exec_sequencer;
    import exec_sequencer_pkg::*;

    localparam int CW = 4;

    typedef struct {
        logic [3:0]  rd;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic [2:0]  op;
        logic [31:0] data;
        logic        wb;
        logic        zero;
        int          acc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          instr_valid = 1'b0;
    logic [15:0]   instr_in = 16'h0;
    logic          instr_ready;
    logic [3:0]    read_reg1, read_reg2, write_reg;
    logic [2:0]    alu_ctrl;
    logic [31:0]   alu_result, write_data;
    logic          alu_zero, reg_write, done, zero_flag, busy;
    logic [CW-1:0] instr_count;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    exp_t sb[$];

    exec_sequencer #(.CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_in    (instr_in),
        .instr_ready (instr_ready),
        .read_reg1   (read_reg1),
        .read_reg2   (read_reg2),
        .alu_ctrl    (alu_ctrl),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero),
        .write_reg   (write_reg),
        .write_data  (write_data),
        .reg_write   (reg_write),
        .done        (done),
        .zero_flag   (zero_flag),
        .busy        (busy),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Register file environment: preloaded once during the initial reset.
    logic [31:0] regs [16];
    logic        loaded = 1'b0;
    always @(posedge clk) begin
        if (rst) begin
            if (!loaded) begin
                for (int i = 0; i < 16; i++) regs[i] <= 32'h0;
                regs[1] <= 32'd10;
                regs[2] <= 32'd20;
                regs[5] <= 32'hF0;
                regs[6] <= 32'h3C;
                loaded  <= 1'b1;
            end
        end else if (reg_write) begin
            regs[write_reg] <= write_data;
        end
    end

    logic [31:0] op_a, op_b;
    always_comb begin
        op_a = regs[read_reg1];
        op_b = regs[read_reg2];
        case (alu_ctrl)
            3'b000:  alu_result = op_a + op_b;
            3'b001:  alu_result = op_a - op_b;
            3'b010:  alu_result = op_a & op_b;
            3'b011:  alu_result = op_a | op_b;
            3'b100:  alu_result = op_a ^ op_b;
            3'b101:  alu_result = {31'b0, $signed(op_a) < $signed(op_b)};
            3'b110:  alu_result = op_a << op_b[4:0];
            default: alu_result = op_a >> op_b[4:0];
        endcase
        alu_zero = (alu_result == 32'h0);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops on every retire pulse, then checks post-retire state.
    logic post_pend = 1'b0;
    logic exp_zero_q = 1'b0;
    int   exp_count = 0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            exp_count = 0;
            post_pend = 1'b0;
        end else begin
            if (post_pend) begin
                check("zero_flag", 32'(zero_flag), 32'(exp_zero_q));
                check("instr_count", 32'(instr_count), 32'(exp_count % 16));
                check("done_one_cycle", 32'(done), 32'(0));
                post_pend = 1'b0;
            end
            if (reg_write && !done)
                check("reg_write_outside_wb", 32'(reg_write), 32'(0));
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'(0));
                end else begin
                    e = sb.pop_front();
                    check("write_reg", 32'(write_reg), 32'(e.rd));
                    check("write_data", write_data, e.data);
                    check("reg_write", 32'(reg_write), 32'(e.wb));
                    check("read_reg1_stable", 32'(read_reg1), 32'(e.rs1));
                    check("read_reg2_stable", 32'(read_reg2), 32'(e.rs2));
                    check("alu_ctrl_stable", 32'(alu_ctrl), 32'(e.op));
                    check("done_latency", 32'(cyc - e.acc), 32'(2));
                    check("busy_in_wb", 32'(busy), 32'(1));
                    exp_zero_q = e.zero;
                    exp_count  = exp_count + 1;
                    post_pend  = 1'b1;
                end
            end
        end
    end

    // Drives instr_valid until accepted; leaves instr_valid high on return.
    task automatic issue(input exp_t e, input logic nowb, input logic push, output int acc);
        instr_valid = 1'b1;
        instr_in    = {nowb, e.op, e.rd, e.rs1, e.rs2};
        acc = -1;
        for (int t = 0; t < 20; t++) begin
            if (instr_ready) begin
                @(posedge clk);
                #1;
                acc   = cyc;
                e.acc = cyc;
                if (push) sb.push_back(e);
                return;
            end
            @(negedge clk);
        end
        check("accept_timeout", 32'(0), 32'(1));
    endtask

    task automatic run(input logic nowb, input logic [2:0] op, input logic [3:0] rd,
                       input logic [3:0] rs1, input logic [3:0] rs2,
                       input logic [31:0] data, input logic zero);
        exp_t e;
        int   acc;
        e = '{rd: rd, rs1: rs1, rs2: rs2, op: op, data: data, wb: !nowb, zero: zero, acc: 0};
        issue(e, nowb, 1'b1, acc);
        instr_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] snap [16];
        logic [31:0] exp_regs [16];
        exp_t e;
        int   acc1, acc2, acc3;

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_reg_write", 32'(reg_write), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_zero_flag", 32'(zero_flag), 32'(0));
        check("rst_instr_count", 32'(instr_count), 32'(0));
        check("rst_write_reg", 32'(write_reg), 32'(0));
        check("rst_write_data", write_data, 32'(0));
        check("rst_read_regs", 32'({read_reg1, read_reg2, alu_ctrl}), 32'(0));
        rst = 1'b0;
        #1;
        check("ready_after_rst", 32'(instr_ready), 32'(1));

        // op, rd, rs1, rs2 -> hand-computed result and zero flag
        run(1'b0, 3'b000, 4'd3, 4'd1, 4'd2, 32'd30,   1'b0); // ADD 10+20
        run(1'b0, 3'b001, 4'd4, 4'd1, 4'd1, 32'd0,    1'b1); // SUB 10-10
        run(1'b1, 3'b001, 4'd4, 4'd2, 4'd1, 32'd10,   1'b0); // SUB 20-10, no write
        run(1'b0, 3'b010, 4'd7, 4'd5, 4'd6, 32'h30,   1'b0); // AND
        run(1'b0, 3'b011, 4'd8, 4'd5, 4'd6, 32'hFC,   1'b0); // OR
        run(1'b0, 3'b100, 4'd0, 4'd5, 4'd6, 32'hCC,   1'b0); // XOR into r0
        run(1'b0, 3'b000, 4'd9, 4'd3, 4'd0, 32'hEA,   1'b0); // 0x1E + 0xCC

        // Back-to-back with instr_valid held high throughout.
        e = '{rd: 4'd11, rs1: 4'd1, rs2: 4'd2, op: 3'b000, data: 32'd30, wb: 1'b1, zero: 1'b0, acc: 0};
        issue(e, 1'b0, 1'b1, acc1);
        instr_in = 16'h0FFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("ready_low_after_accept1", 32'(instr_ready), 32'(0));
        end
        @(negedge clk);
        e = '{rd: 4'd12, rs1: 4'd2, rs2: 4'd1, op: 3'b001, data: 32'd10, wb: 1'b1, zero: 1'b0, acc: 0};
        issue(e, 1'b0, 1'b1, acc2);
        check("accept_spacing", 32'(acc2 - acc1), 32'(4));
        instr_in = 16'h7DFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("ready_low_after_accept2", 32'(instr_ready), 32'(0));
        end
        instr_valid = 1'b0;
        repeat (2) @(negedge clk);

        // Reset during EXEC aborts the instruction.
        e = '{rd: 4'd13, rs1: 4'd1, rs2: 4'd2, op: 3'b000, data: 32'd30, wb: 1'b1, zero: 1'b0, acc: 0};
        issue(e, 1'b0, 1'b0, acc3);
        instr_valid = 1'b0;
        for (int i = 0; i < 16; i++) snap[i] = regs[i];
        @(posedge clk);
        #2;
        check("busy_in_exec", 32'(busy), 32'(1));
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_reg_write", 32'(reg_write), 32'(0));
        check("abort_done", 32'(done), 32'(0));
        check("abort_instr_count", 32'(instr_count), 32'(0));
        check("abort_ready", 32'(instr_ready), 32'(1));
        check("abort_write_data", write_data, 32'(0));
        check("abort_read_regs", 32'({read_reg1, read_reg2, alu_ctrl, write_reg}), 32'(0));
        repeat (3) @(negedge clk);
        for (int i = 0; i < 16; i++) check($sformatf("abort_reg_r%0d", i), regs[i], snap[i]);
        rst = 1'b0;
        #1;
        check("ready_after_abort", 32'(instr_ready), 32'(1));

        // Retire 16 instructions; the 4-bit counter must wrap to zero.
        for (int i = 0; i < 16; i++) run(1'b0, 3'b000, 4'd10, 4'd1, 4'd2, 32'd30, 1'b0);
        repeat (4) @(negedge clk);
        check("count_wrapped", 32'(instr_count), 32'(0));
        check("ready_idle_end", 32'(instr_ready), 32'(1));

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'(0));
        for (int i = 0; i < 16; i++) exp_regs[i] = 32'h0;
        exp_regs[0]  = 32'hCC;
        exp_regs[1]  = 32'd10;
        exp_regs[2]  = 32'd20;
        exp_regs[3]  = 32'd30;
        exp_regs[4]  = 32'd0;
        exp_regs[5]  = 32'hF0;
        exp_regs[6]  = 32'h3C;
        exp_regs[7]  = 32'h30;
        exp_regs[8]  = 32'hFC;
        exp_regs[9]  = 32'hEA;
        exp_regs[10] = 32'd30;
        exp_regs[11] = 32'd30;
        exp_regs[12] = 32'd10;
        for (int i = 0; i < 16; i++) check($sformatf("final_r%0d", i), regs[i], exp_regs[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/exec_sequencer.md
EXEC_SEQUENCER -- requirements
Module: exec_sequencer

Interface
REQ-001 Parameter CNT_W, default 16, width of the retired-instruction counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 instr_valid  input  1  upstream instruction word is valid.
REQ-005 instr_in  input  16  [15]=no_wb, [14:12]=alu op, [11:8]=rd, [7:4]=rs1, [3:0]=rs2.
REQ-006 instr_ready  output  1  sequencer can accept an instruction.
REQ-007 read_reg1  output  4  register-file read address, port 1 (rs1).
REQ-008 read_reg2  output  4  register-file read address, port 2 (rs2).
REQ-009 alu_ctrl  output  3  ALU operation select.
REQ-010 alu_result  input  32  combinational ALU result (ALU operands come from the register-file read ports).
REQ-011 alu_zero  input  1  ALU zero flag.
REQ-012 write_reg  output  4  register-file write address.
REQ-013 write_data  output  32  register-file write data.
REQ-014 reg_write  output  1  register-file write enable.
REQ-015 done  output  1  one-cycle pulse when an instruction retires.
REQ-016 zero_flag  output  1  registered alu_zero of the last retired instruction.
REQ-017 busy  output  1  high in any state other than IDLE.
REQ-018 instr_count  output  CNT_W  number of retired instructions.

Function
REQ-019 FSM states SHALL be IDLE, READ, EXEC, WB.
REQ-020 instr_ready SHALL be 1 only in IDLE; handshake = instr_valid & instr_ready at a rising edge.
REQ-021 On handshake, instr_in SHALL be latched into an instruction register and the state SHALL go to READ.
REQ-022 In READ, read_reg1, read_reg2 and alu_ctrl SHALL drive rs1, rs2 and op from the latched instruction; the next state SHALL be EXEC.
REQ-023 Those fields SHALL remain stable through EXEC and WB.
REQ-024 At the rising edge ending EXEC, alu_result SHALL be captured into write_data and alu_zero into a pending zero register; the next state SHALL be WB.
REQ-025 In WB, reg_write SHALL be 1 if no_wb=0 and 0 if no_wb=1, with write_reg=rd; reg_write SHALL be 0 in all other states.
REQ-026 In WB, done SHALL be 1 for exactly one cycle.
REQ-027 At the edge ending WB: zero_flag SHALL load the pending zero value, instr_count SHALL increment, and the state SHALL return to IDLE.
REQ-028 Latency: handshake at edge E0; reg_write and done high between E2 and E3; register-file write at E3; next accept no earlier than E4; throughput is 1 instruction per 4 cycles.
REQ-029 instr_count SHALL wrap from 2^CNT_W-1 to 0 with no flag.
REQ-030 instr_valid and instr_in SHALL be ignored while busy=1; no queueing.
REQ-031 Writes to rd=0 SHALL be performed like any other register.

Reset
REQ-032 While rst=1, asynchronously: state=IDLE; reg_write, done, zero_flag, busy=0; instr_count=0; write_reg, write_data, read_reg1, read_reg2, alu_ctrl=0.
REQ-033 Reset asserted mid-instruction SHALL abort it with no register-file write and no count increment.
REQ-034 instr_ready SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-035 A shared package SHALL hold the state encoding, instruction field bit positions, ALU op codes (000=ADD, 001=SUB, ...) and CNT_W default.
REQ-036 The FSM and datapath registers SHALL be one module; an optional combinational sub-module instr_decode SHALL split fields.

Verification
REQ-037 Preload r1=10, r2=20; issue ADD rd=3 rs1=1 rs2=2 -> reg_write=1 with write_reg=3, write_data=30, done=1 two cycles after accept; instr_count=1.
REQ-038 Issue SUB rd=4 rs1=1 rs2=1 -> write_data=0; zero_flag=1 after retire.
REQ-039 Issue SUB with no_wb=1, rs1=2, rs2=1 -> reg_write never 1; done pulses; zero_flag=0; r4 unchanged.
REQ-040 Hold instr_valid=1 with two instructions queued by the bench -> instr_ready=0 for 3 cycles after each accept; second accept exactly 4 cycles after the first.
REQ-041 Assert rst during EXEC -> reg_write=0 and busy=0 immediately; instr_count=0; no register changes.
REQ-042 Preload instr_count near wrap (CNT_W=4, retire 16 instructions) -> instr_count returns to 0.
